// File: rtl/dmem_ws_if.sv
// dmem_ws_if: request/response bundle between the core's memory FSM and dmem_ws
interface dmem_ws_if;
  logic req, we, byte_acc, ready, err, busy;
  logic [31:0] a, wd, rd;
  modport master(output req, we, byte_acc, a, wd, input rd, ready, err, busy);
  modport slave(input req, we, byte_acc, a, wd, output rd, ready, err, busy);
endinterface

// File: rtl/dmem_ws.sv
// dmem_ws: wait-state word memory with req/ready handshake, byte lanes and error response
module dmem_ws #(
  parameter int    DEPTH       = 64,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input logic       clk,
  input logic       reset,
  dmem_ws_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = WAIT_CYCLES > 0 ? CW'(WAIT_CYCLES - 1) : '0;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [31:0] mem [DEPTH];
  logic [31:0] a_q, wd_q, word;
  logic we_q, byte_q, bad, resp;
  logic [AW-1:0] idx;
  logic [4:0] sh;
  assign idx = a_q[AW+1:2];
  assign sh = {a_q[1:0], 3'b000};
  // upper address bits beyond the array mean out of range; no aliasing
  assign bad = (|a_q[31:AW+2]) || (!byte_q && a_q[1:0] != 2'b00);
  assign resp = state == S_RESP;
  assign word = mem[idx];
  assign bus.rd = resp && !bad && !we_q ? (byte_q ? {24'b0, word[sh +: 8]} : word) : '0;
  assign bus.ready = resp;
  assign bus.err = resp && bad;
  assign bus.busy = state != S_IDLE;
  always_comb begin
    nstate = state == S_IDLE ? (bus.req ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE)
           : state == S_WAIT ? (cnt == '0 ? S_RESP : S_WAIT)
           : S_IDLE;
    ncnt = state == S_IDLE ? CNT_INIT : (cnt == '0 ? cnt : cnt - CW'(1));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
    end
  end
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.req) begin
      a_q <= bus.a;
      wd_q <= bus.wd;
      we_q <= bus.we;
      byte_q <= bus.byte_acc;
    end
  end
  always_ff @(posedge clk) begin
    if (resp && we_q && !bad && !reset) begin
      if (byte_q) mem[idx][sh +: 8] <= wd_q[7:0];
      else mem[idx] <= wd_q;
    end
  end
endmodule

// File: tb/tb_dmem_ws.sv
// tb_dmem_ws: randomized scoreboard bench for dmem_ws against a behavioural memory model
module tb_dmem_ws;
  localparam int W = 2;
  localparam int D = 64;
  typedef struct {logic [31:0] rd; logic err; int cyc;} exp_t;
  logic clk = 0, reset = 1;
  int checks = 0, failures = 0, cyc = 0;
  exp_t q[$];
  logic [31:0] model [D];
  dmem_ws_if bus();
  dmem_ws_if bus0();
  dmem_ws #(.DEPTH(D), .WAIT_CYCLES(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  dmem_ws #(.DEPTH(D), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && bus.ready === 1'b1) begin
      if (q.size() == 0) check("unexpected_ready", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("rd", bus.rd, e.rd);
        check("err", 32'(bus.err), 32'(e.err));
        check("latency", 32'(cyc), 32'(e.cyc));
        check("busy_in_resp", 32'(bus.busy), 32'd1);
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'd1, 32'd0);
    bus.req = 0;
  endtask
  task automatic access(input logic w, input logic b, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int i, lane;
    wait_idle();
    i = int'(addr >> 2);
    lane = int'(addr & 3);
    e.err = (addr >> 2) >= D || (!b && lane != 0);
    e.rd = 0;
    e.cyc = cyc + W + 1;
    if (!e.err && !w) e.rd = b ? (model[i] >> (8 * lane)) & 32'hFF : model[i];
    if (!e.err && w) model[i] = b ? (model[i] & ~(32'hFF << (8 * lane))) | ({24'b0, data[7:0]} << (8 * lane)) : data;
    q.push_back(e);
    bus.req = 1; bus.we = w; bus.byte_acc = b; bus.a = addr; bus.wd = data;
    @(negedge clk);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    bus.req = 1'($urandom_range(0, 1)); bus.we = 1'($urandom_range(0, 1));
    bus.byte_acc = 1'($urandom_range(0, 1)); bus.a = $urandom; bus.wd = $urandom;
  endtask
  initial begin
    logic [31:0] addr;
    logic b, w;
    int r, n;
    bus.req = 0; bus.we = 0; bus.byte_acc = 0; bus.a = 0; bus.wd = 0;
    bus0.req = 0; bus0.we = 0; bus0.byte_acc = 0; bus0.a = 0; bus0.wd = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_rd", bus.rd, 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    // zero wait states, req held high across back-to-back accesses
    bus0.req = 1; bus0.we = 1; bus0.a = 32'h64; bus0.wd = 32'd7;
    @(negedge clk);
    check("w0_ready1", 32'(bus0.ready), 32'd1);
    check("w0_err1", 32'(bus0.err), 32'd0);
    bus0.we = 0;
    @(negedge clk);
    check("w0_idle_ready", 32'(bus0.ready), 32'd0);
    check("w0_idle_busy", 32'(bus0.busy), 32'd0);
    @(negedge clk);
    check("w0_ready2", 32'(bus0.ready), 32'd1);
    check("w0_rd", bus0.rd, 32'd7);
    bus0.req = 0;
    for (int i = 0; i < D; i++) access(1, 0, 32'(i) << 2, $urandom);
    access(1, 0, 32'h60, 32'h11223344);
    access(0, 0, 32'h60, 0);
    access(1, 1, 32'h61, 32'h000000AB);
    access(0, 0, 32'h60, 0);
    access(0, 1, 32'h61, 0);
    access(0, 1, 32'h63, 0);
    access(0, 0, 32'h62, 0);
    access(1, 0, 32'h62, 32'hFFFFFFFF);
    access(0, 0, 32'h60, 0);
    access(0, 0, 32'h100, 0);
    access(1, 0, 32'h100, 32'h55AA55AA);
    access(0, 0, 32'h00, 0);
    // abort a write with reset in its second wait cycle
    wait_idle();
    bus.req = 1; bus.we = 1; bus.byte_acc = 0; bus.a = 32'h64; bus.wd = 32'hDEADBEEF;
    @(negedge clk);
    bus.req = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort_ready", 32'(bus.ready), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    access(0, 0, 32'h64, 0);
    for (int k = 0; k < 150; k++) begin
      b = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r == 0) addr = 32'($urandom_range(256, 511));
      else begin
        addr = 32'($urandom_range(0, D - 1)) << 2;
        if (b || r == 1) addr[1:0] = 2'($urandom_range(0, 3));
      end
      access(w, b, addr, $urandom);
    end
    wait_idle();
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
